// File: rtl/key_click_decoder.sv
// Groups debounced key-press pulses into single, double and triple click events.
// Each group closes with one registered event pulse, either on window timeout or on the third press.
module key_click_decoder #(
  parameter int CLK_FREQ  = 100000000,
  parameter int WIN_MS    = 300,
  localparam int WIN_CYC  = CLK_FREQ / 1000 * WIN_MS,
  localparam int TW       = (WIN_CYC > 2) ? $clog2(WIN_CYC) : 1
) (
  input  logic       clk_i,
  input  logic       rstn_i,
  input  logic       key_cap_i,
  output logic       single_o,
  output logic       double_o,
  output logic       triple_o,
  output logic       busy_o,
  output logic [1:0] click_cnt_o
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [TW-1:0] TMAX = TW'(WIN_CYC - 1);

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [1:0]    cnt_q;
  logic          single_q;
  logic          double_q;
  logic          triple_pend_q;
  logic          triple_q;

  // Group FSM. The triple event leaves the FSM one cycle early and is delayed through triple_pend_q.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      timer_q       <= {TW{1'b0}};
      cnt_q         <= 2'd0;
      single_q      <= 1'b0;
      double_q      <= 1'b0;
      triple_pend_q <= 1'b0;
      triple_q      <= 1'b0;
    end else begin
      single_q      <= 1'b0;
      double_q      <= 1'b0;
      triple_pend_q <= 1'b0;
      triple_q      <= triple_pend_q;
      case (state_q)
        S_IDLE: begin
          if (key_cap_i) begin
            state_q <= S_WAIT;
            cnt_q   <= 2'd1;
            timer_q <= {TW{1'b0}};
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT: begin
          // A press on the timeout edge is counted and the window restarts.
          if (key_cap_i) begin
            if (cnt_q == 2'd2) begin
              triple_pend_q <= 1'b1;
              state_q       <= S_IDLE;
              cnt_q         <= 2'd0;
              timer_q       <= {TW{1'b0}};
            end else begin
              cnt_q   <= 2'd2;
              timer_q <= {TW{1'b0}};
            end
          end else if (timer_q == TMAX) begin
            single_q <= (cnt_q == 2'd1);
            double_q <= (cnt_q == 2'd2);
            state_q  <= S_IDLE;
            cnt_q    <= 2'd0;
            timer_q  <= {TW{1'b0}};
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= 2'd0;
          timer_q <= {TW{1'b0}};
        end
      endcase
    end
  end

  assign single_o    = single_q;
  assign double_o    = double_q;
  assign triple_o    = triple_q;
  assign busy_o      = (state_q == S_WAIT);
  assign click_cnt_o = cnt_q;

endmodule

// File: tb/tb_key_click_decoder.sv
// Randomized and directed bench for key_click_decoder against a timestamp-based click model.
module tb_key_click_decoder;

  localparam int WIN = 10;

  logic       clk;
  logic       rstn_i;
  logic       key_cap_i;
  logic       single_o;
  logic       double_o;
  logic       triple_o;
  logic       busy_o;
  logic [1:0] click_cnt_o;

  key_click_decoder #(.CLK_FREQ(1000), .WIN_MS(10)) dut (
    .clk_i      (clk),
    .rstn_i     (rstn_i),
    .key_cap_i  (key_cap_i),
    .single_o   (single_o),
    .double_o   (double_o),
    .triple_o   (triple_o),
    .busy_o     (busy_o),
    .click_cnt_o(click_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int pulses = 0;

  // Model: a group is remembered as its press count and the time of its last press.
  int t = 0;
  int grp_n = 0;
  int last_t = 0;
  int tri_due = -1;
  bit exp_s, exp_d, exp_t;

  typedef struct {int id; int e; int sig; int val;} lit_t;
  lit_t lits[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (model t=%0d)", nm, act, exp, t);
    end
  endtask

  task automatic model_edge(input bit p, input bit in_rst);
    exp_s = 1'b0;
    exp_d = 1'b0;
    exp_t = 1'b0;
    if (in_rst) begin
      grp_n   = 0;
      tri_due = -1;
    end else begin
      t++;
      exp_t = (tri_due == t);
      if (grp_n == 0) begin
        if (p) begin
          grp_n  = 1;
          last_t = t;
        end
      end else if (p) begin
        if (grp_n == 2) begin
          grp_n   = 0;
          tri_due = t + 1;
        end else begin
          grp_n  = 2;
          last_t = t;
        end
      end else if (t - last_t == WIN) begin
        exp_s = (grp_n == 1);
        exp_d = (grp_n == 2);
        grp_n = 0;
      end
    end
  endtask

  task automatic step(input bit p, input bit r);
    @(negedge clk);
    key_cap_i = p;
    rstn_i    = r;
    #1;
    if (!r) begin
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      chk("rst_cnt", {30'd0, click_cnt_o}, 32'd0);
      chk("rst_pulses", {29'd0, single_o, double_o, triple_o}, 32'd0);
    end
    @(posedge clk);
    model_edge(p, !r);
    #1;
    chk("single", {31'd0, single_o}, {31'd0, exp_s});
    chk("double", {31'd0, double_o}, {31'd0, exp_d});
    chk("triple", {31'd0, triple_o}, {31'd0, exp_t});
    chk("busy", {31'd0, busy_o}, (grp_n != 0) ? 32'd1 : 32'd0);
    chk("cnt", {30'd0, click_cnt_o}, 32'(grp_n));
    pulses += int'(single_o) + int'(double_o) + int'(triple_o);
  endtask

  function automatic logic [31:0] sigval(input int s);
    case (s)
      0:       return {31'd0, single_o};
      1:       return {31'd0, double_o};
      2:       return {31'd0, triple_o};
      3:       return {31'd0, busy_o};
      4:       return {30'd0, click_cnt_o};
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  task automatic add(input int id, input int e, input int s, input int v);
    lit_t l;
    l.id = id; l.e = e; l.sig = s; l.val = v;
    lits.push_back(l);
  endtask

  task automatic run_dir(input int id, input int a, input int b, input int c,
                         input int rs, input int n);
    bit p;
    bit r;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    pulses = 0;
    for (int k = 1; k <= n; k++) begin
      p = (k == a) || (k == b) || (k == c);
      r = !((rs != 0) && (k == rs || k == rs + 1));
      step(p, r);
      foreach (lits[i]) begin
        if (lits[i].id == id && lits[i].e == k)
          chk($sformatf("T%0d_e%0d_s%0d", id, k, lits[i].sig), sigval(lits[i].sig), 32'(lits[i].val));
      end
    end
  endtask

  initial begin
    key_cap_i = 1'b0;
    rstn_i    = 1'b0;
    // signal codes: 0 single, 1 double, 2 triple, 3 busy, 4 cnt
    add(1, 4, 3, 0);  add(1, 5, 3, 1);  add(1, 14, 3, 1); add(1, 15, 3, 0);
    add(1, 14, 0, 0); add(1, 15, 0, 1); add(1, 16, 0, 0);
    add(2, 12, 4, 2); add(2, 15, 0, 0); add(2, 21, 1, 0); add(2, 22, 1, 1); add(2, 23, 1, 0);
    add(3, 18, 3, 0); add(3, 18, 2, 0); add(3, 19, 2, 1); add(3, 20, 2, 0); add(3, 22, 1, 0);
    add(4, 15, 0, 0); add(4, 15, 4, 2); add(4, 24, 1, 0); add(4, 25, 1, 1);
    add(5, 8, 4, 1);  add(5, 8, 3, 1);  add(5, 11, 3, 0); add(5, 11, 4, 0);
    add(6, 15, 0, 1); add(6, 16, 3, 1); add(6, 16, 4, 1); add(6, 25, 0, 0); add(6, 26, 0, 1);

    run_dir(1, 5, 0, 0, 0, 30);
    run_dir(2, 5, 12, 0, 0, 30);
    run_dir(3, 5, 12, 18, 0, 30);
    run_dir(4, 5, 15, 0, 0, 35);
    run_dir(5, 5, 0, 0, 9, 40);
    chk("T5_no_pulse", 32'(pulses), 32'd0);
    run_dir(6, 5, 16, 0, 0, 35);

    step(1'b0, 1'b0);
    for (int i = 0; i < 5000; i++) begin
      step($urandom_range(0, 99) < 12, $urandom_range(0, 799) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
